// File: rtl/overture_control.sv
// overture_control: fetch/decode/execute controller for the 8-bit Overture
// datapath. Fetches instruction bytes over a req/ack handshake, holds r0-r5,
// drives the external ALU and moves bytes through valid/ready in/out ports.
module overture_control #(
    parameter int unsigned UUID     = 0,
    parameter string       NAME     = "",
    parameter logic [7:0]  RESET_PC = 8'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    output logic       prog_req,
    output logic [7:0] prog_addr,
    input  logic       prog_ack,
    input  logic [7:0] prog_data,
    output logic [7:0] alu_instruction,
    output logic [7:0] alu_in1,
    output logic [7:0] alu_in2,
    input  logic [7:0] alu_result,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_IN_WAIT,
        S_OUT_WAIT
    } state_e;

    // Identification parameters are carried for the instance only.
    logic unused_params;
    assign unused_params = (UUID == 0) && (NAME == "");

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] regs_q [6];
    logic [7:0] regs_d [6];
    logic       prog_req_q, prog_req_d;
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_data_q, out_data_d;
    logic [7:0] alu_instr_q, alu_instr_d;

    logic [2:0] src_idx;
    logic [2:0] dst_idx;
    logic [7:0] src_val;
    logic       cond_true;
    logic       done;
    logic       jump;

    assign src_idx = ir_q[5:3];
    assign dst_idx = ir_q[2:0];

    // Copy source operand; index 7 (and 6, which is the input port) reads zero.
    always_comb begin
        src_val = '0;
        if (src_idx < 3'd6) begin
            src_val = regs_q[src_idx];
        end
    end

    // Branch condition on signed r3 selected by ir[2:0].
    always_comb begin
        logic zero;
        logic neg;
        zero = (regs_q[3] == 8'h00);
        neg  = regs_q[3][7];
        cond_true = 1'b0;
        case (ir_q[2:0])
            3'd0:    cond_true = 1'b0;
            3'd1:    cond_true = zero;
            3'd2:    cond_true = neg;
            3'd3:    cond_true = neg | zero;
            3'd4:    cond_true = 1'b1;
            3'd5:    cond_true = ~zero;
            3'd6:    cond_true = ~neg;
            default: cond_true = ~neg & ~zero;
        endcase
    end

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        regs_d     = regs_q;
        out_data_d = out_data_q;
        done       = 1'b0;
        jump       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (prog_ack) begin
                    ir_d    = prog_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (ir_q[7:6])
                    2'b00: begin
                        regs_d[0] = {2'b00, ir_q[5:0]};
                        done      = 1'b1;
                    end
                    2'b01: begin
                        regs_d[3] = alu_result;
                        done      = 1'b1;
                    end
                    2'b10: begin
                        if (src_idx == 3'd6) begin
                            state_d = S_IN_WAIT;
                        end else if (dst_idx == 3'd6) begin
                            out_data_d = src_val;
                            state_d    = S_OUT_WAIT;
                        end else begin
                            if (dst_idx < 3'd6) begin
                                regs_d[dst_idx] = src_val;
                            end
                            done = 1'b1;
                        end
                    end
                    default: begin
                        jump = cond_true;
                        done = 1'b1;
                    end
                endcase
            end
            S_IN_WAIT: begin
                if (in_valid) begin
                    if (dst_idx == 3'd6) begin
                        out_data_d = in_data;
                        state_d    = S_OUT_WAIT;
                    end else begin
                        if (dst_idx < 3'd6) begin
                            regs_d[dst_idx] = in_data;
                        end
                        done = 1'b1;
                    end
                end
            end
            S_OUT_WAIT: begin
                if (out_ready) begin
                    done = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (done) begin
            pc_d    = jump ? regs_q[0] : pc_q + 8'd1;
            state_d = run ? S_FETCH : S_IDLE;
        end

        // Outputs are registered, so they are derived from the state being entered.
        prog_req_d  = (state_d == S_FETCH);
        in_ready_d  = (state_d == S_IN_WAIT);
        out_valid_d = (state_d == S_OUT_WAIT);
        alu_instr_d = '0;
        if (state_d == S_EXEC && ir_d[7:6] == 2'b01) begin
            alu_instr_d = {5'b00000, ir_d[2:0]};
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            regs_q      <= '{default: '0};
            prog_req_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            alu_instr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            regs_q      <= regs_d;
            prog_req_q  <= prog_req_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            alu_instr_q <= alu_instr_d;
        end
    end

    assign prog_req        = prog_req_q;
    assign prog_addr       = pc_q;
    assign pc              = pc_q;
    assign alu_instruction = alu_instr_q;
    assign alu_in1         = regs_q[1];
    assign alu_in2         = regs_q[2];
    assign in_ready        = in_ready_q;
    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;

endmodule

// File: tb/tb_overture_control.sv
// Directed bench for overture_control: a program table stepped one
// instruction at a time, plus handshake, run-drop and reset sequences.
module tb_overture_control;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       prog_req;
    logic [7:0] prog_addr;
    logic       prog_ack;
    logic [7:0] prog_data;
    logic [7:0] alu_instruction;
    logic [7:0] alu_in1;
    logic [7:0] alu_in2;
    logic [7:0] alu_result;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] pc;

    int total = 0;
    int bad   = 0;
    int out_cnt = 0;
    logic [7:0] last_out = 8'h00;

    overture_control #(
        .UUID(7),
        .NAME("ov0"),
        .RESET_PC(8'hFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .run(run),
        .prog_req(prog_req),
        .prog_addr(prog_addr),
        .prog_ack(prog_ack),
        .prog_data(prog_data),
        .alu_instruction(alu_instruction),
        .alu_in1(alu_in1),
        .alu_in2(alu_in2),
        .alu_result(alu_result),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .pc(pc)
    );

    always #5 clk = ~clk;

    // Combinational ALU model: OR, NAND, NOR, AND, ADD, SUB.
    always_comb begin
        case (alu_instruction[2:0])
            3'd0:    alu_result = alu_in1 | alu_in2;
            3'd1:    alu_result = ~(alu_in1 & alu_in2);
            3'd2:    alu_result = ~(alu_in1 | alu_in2);
            3'd3:    alu_result = alu_in1 & alu_in2;
            3'd4:    alu_result = alu_in1 + alu_in2;
            3'd5:    alu_result = alu_in1 - alu_in2;
            default: alu_result = 8'h00;
        endcase
    end

    always @(posedge clk) begin
        if (out_valid && out_ready) begin
            out_cnt  <= out_cnt + 1;
            last_out <= out_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Waits (bounded) for prog_req at a falling edge; n = falling edges consumed.
    task automatic wait_req(input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!prog_req && n < 40);
        if (!prog_req) begin
            bad++;
            total++;
            $display("FAIL %s: prog_req timeout got 0 expected 1", name);
        end
    endtask

    task automatic feed(input logic [7:0] instr);
        prog_data = instr;
        prog_ack  = 1'b1;
        @(posedge clk);
        #1 prog_ack = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  instr;
        logic [7:0]  in_byte;
        int          cycles;
        logic [7:0]  exp_alu;
        logic [7:0]  exp_a1;
        logic [7:0]  exp_a2;
        bit          exp_out;
        logic [7:0]  exp_out_data;
    } vec_t;

    vec_t vecs[27];

    initial begin
        int n;
        int exp_cnt;
        int inr;
        int ovc;
        int reqc;

        // addr, instr, in_byte, cycles-to-next-fetch, alu_instruction in EXEC,
        // r1/r2 afterwards, output produced, output byte
        vecs[0]  = '{8'hFF, 8'h05, 8'h00, 2, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00};
        vecs[1]  = '{8'h00, 8'h81, 8'h00, 2, 8'h00, 8'h05, 8'h00, 1'b0, 8'h00};
        vecs[2]  = '{8'h01, 8'h03, 8'h00, 2, 8'h00, 8'h05, 8'h00, 1'b0, 8'h00};
        vecs[3]  = '{8'h02, 8'h82, 8'h00, 2, 8'h00, 8'h05, 8'h03, 1'b0, 8'h00};
        vecs[4]  = '{8'h03, 8'h44, 8'h00, 2, 8'h04, 8'h05, 8'h03, 1'b0, 8'h00};
        vecs[5]  = '{8'h04, 8'h9E, 8'h00, 3, 8'h00, 8'h05, 8'h03, 1'b1, 8'h08};
        vecs[6]  = '{8'h05, 8'h81, 8'h00, 2, 8'h00, 8'h03, 8'h03, 1'b0, 8'h00};
        vecs[7]  = '{8'h06, 8'h05, 8'h00, 2, 8'h00, 8'h03, 8'h03, 1'b0, 8'h00};
        vecs[8]  = '{8'h07, 8'h82, 8'h00, 2, 8'h00, 8'h03, 8'h05, 1'b0, 8'h00};
        vecs[9]  = '{8'h08, 8'h45, 8'h00, 2, 8'h05, 8'h03, 8'h05, 1'b0, 8'h00};
        vecs[10] = '{8'h09, 8'h9E, 8'h00, 3, 8'h00, 8'h03, 8'h05, 1'b1, 8'hFE};
        vecs[11] = '{8'h0A, 8'h20, 8'h00, 2, 8'h00, 8'h03, 8'h05, 1'b0, 8'h00};
        vecs[12] = '{8'h0B, 8'hC2, 8'h00, 2, 8'h00, 8'h03, 8'h05, 1'b0, 8'h00};
        vecs[13] = '{8'h20, 8'hC7, 8'h00, 2, 8'h00, 8'h03, 8'h05, 1'b0, 8'h00};
        vecs[14] = '{8'h21, 8'hC3, 8'h00, 2, 8'h00, 8'h03, 8'h05, 1'b0, 8'h00};
        vecs[15] = '{8'h20, 8'hBE, 8'h00, 3, 8'h00, 8'h03, 8'h05, 1'b1, 8'h00};
        vecs[16] = '{8'h21, 8'h8F, 8'h00, 2, 8'h00, 8'h03, 8'h05, 1'b0, 8'h00};
        vecs[17] = '{8'h22, 8'hB1, 8'hA5, 3, 8'h00, 8'hA5, 8'h05, 1'b0, 8'h00};
        vecs[18] = '{8'h23, 8'hC0, 8'h00, 2, 8'h00, 8'hA5, 8'h05, 1'b0, 8'h00};
        vecs[19] = '{8'h24, 8'h9E, 8'h00, 3, 8'h00, 8'hA5, 8'h05, 1'b1, 8'hFE};
        vecs[20] = '{8'h25, 8'h3F, 8'h00, 2, 8'h00, 8'hA5, 8'h05, 1'b0, 8'h00};
        vecs[21] = '{8'h26, 8'hC4, 8'h00, 2, 8'h00, 8'hA5, 8'h05, 1'b0, 8'h00};
        vecs[22] = '{8'h3F, 8'h43, 8'h00, 2, 8'h03, 8'hA5, 8'h05, 1'b0, 8'h00};
        vecs[23] = '{8'h40, 8'hC5, 8'h00, 2, 8'h00, 8'hA5, 8'h05, 1'b0, 8'h00};
        vecs[24] = '{8'h3F, 8'hB6, 8'h5A, 4, 8'h00, 8'hA5, 8'h05, 1'b1, 8'h5A};
        vecs[25] = '{8'h40, 8'h00, 8'h00, 2, 8'h00, 8'hA5, 8'h05, 1'b0, 8'h00};
        vecs[26] = '{8'h41, 8'hC1, 8'h00, 2, 8'h00, 8'hA5, 8'h05, 1'b0, 8'h00};

        rst = 1'b0;
        run = 1'b0;
        prog_ack = 1'b0;
        prog_data = 8'h00;
        in_data = 8'h00;
        in_valid = 1'b1;
        out_ready = 1'b1;
        exp_cnt = 0;

        // Reset values
        #12;
        chk8("rst_pc", pc, 8'hFF);
        chk8("rst_prog_addr", prog_addr, 8'hFF);
        chk8("rst_prog_req", {7'd0, prog_req}, 8'h00);
        chk8("rst_in_ready", {7'd0, in_ready}, 8'h00);
        chk8("rst_out_valid", {7'd0, out_valid}, 8'h00);
        chk8("rst_out_data", out_data, 8'h00);
        chk8("rst_alu_instr", alu_instruction, 8'h00);
        chk8("rst_alu_in1", alu_in1, 8'h00);
        chk8("rst_alu_in2", alu_in2, 8'h00);

        @(negedge clk);
        rst = 1'b1;
        reqc = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (prog_req) reqc++;
        end
        chki("idle_no_req", reqc, 0);

        run = 1'b1;
        wait_req("start", n);
        chki("idle_to_fetch_cycles", n, 1);

        // Program table
        for (int i = 0; i < 27; i++) begin
            chk8($sformatf("addr[%0d]", i), prog_addr, vecs[i].addr);
            in_data = vecs[i].in_byte;
            feed(vecs[i].instr);
            chk8($sformatf("alu_instr[%0d]", i), alu_instruction, vecs[i].exp_alu);
            wait_req($sformatf("next[%0d]", i), n);
            chki($sformatf("cycles[%0d]", i), n, vecs[i].cycles);
            chk8($sformatf("r1[%0d]", i), alu_in1, vecs[i].exp_a1);
            chk8($sformatf("r2[%0d]", i), alu_in2, vecs[i].exp_a2);
            if (vecs[i].exp_out) exp_cnt++;
            chki($sformatf("out_cnt[%0d]", i), out_cnt, exp_cnt);
            if (vecs[i].exp_out) begin
                chk8($sformatf("out_data[%0d]", i), last_out, vecs[i].exp_out_data);
            end
        end
        chk8("addr_end", prog_addr, 8'h42);

        // In->out copy with stalled in_valid and out_ready
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = 8'h3C;
        feed(8'hB6);
        inr = 0;
        ovc = 0;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (prog_req) break;
            if (in_ready) begin
                inr++;
                if (inr == 4) in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid) begin
                ovc++;
                chk8("stall_out_data_stable", out_data, 8'h3C);
                if (ovc == 3) out_ready = 1'b1;
            end else begin
                out_ready = 1'b0;
            end
        end
        chki("stall_req_seen", {31'd0, prog_req}, 1);
        chki("stall_in_ready_cycles", inr, 4);
        chki("stall_out_valid_cycles", ovc, 3);
        exp_cnt++;
        chki("stall_out_cnt", out_cnt, exp_cnt);
        chk8("stall_out_byte", last_out, 8'h3C);
        chk8("stall_addr", prog_addr, 8'h43);
        chk8("stall_r1", alu_in1, 8'hA5);
        chk8("stall_r2", alu_in2, 8'h05);
        in_valid = 1'b0;

        // run dropped during a stalled fetch
        run = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chki($sformatf("hold_req[%0d]", k), {31'd0, prog_req}, 1);
            chk8($sformatf("hold_addr[%0d]", k), prog_addr, 8'h43);
        end
        feed(8'h07);
        reqc = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (prog_req) reqc++;
        end
        chki("rundrop_no_req", reqc, 0);
        chk8("rundrop_pc", pc, 8'h44);
        run = 1'b1;
        wait_req("rundrop_resume", n);
        chki("rundrop_resume_cycles", n, 1);
        chk8("rundrop_addr", prog_addr, 8'h44);

        // Reset asserted during OUT_WAIT
        out_ready = 1'b0;
        feed(8'h86);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
        chki("ow_out_valid", {31'd0, out_valid}, 1);
        chk8("ow_out_data", out_data, 8'h07);
        #2 rst = 1'b0;
        #1;
        chki("async_out_valid", {31'd0, out_valid}, 0);
        chki("async_prog_req", {31'd0, prog_req}, 0);
        chk8("async_pc", pc, 8'hFF);
        chk8("async_out_data", out_data, 8'h00);
        chk8("async_r1", alu_in1, 8'h00);
        chki("async_no_transfer", out_cnt, exp_cnt);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        wait_req("post_reset", n);
        chk8("post_reset_addr", prog_addr, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/overture_control.md
# overture_control

Instruction fetch/decode/execute controller for the 8-bit Overture datapath: the initiator that drives the combinational ALU block's `Instruction`/`Input_1`/`Input_2` and consumes its `Output`. It fetches bytes from program memory over a req/ack handshake and holds registers r0–r5. It executes the four Overture instruction classes (immediate, calculate, copy, condition) and moves data to and from the external world through valid/ready input and output ports.

## Interface
- `UUID`, 0: instance identifier, passed through unchanged.
- `NAME`, "": instance name, passed through unchanged.
- `RESET_PC`, 8'd0: value loaded into the program counter on reset.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `run`  in  1  1 = fetch/execute; 0 = stop in IDLE after the current instruction.
- `prog_req`  out  1  fetch request.
- `prog_addr`  out  8  fetch address (= pc).
- `prog_ack`  in  1  program memory has `prog_data` valid this cycle.
- `prog_data`  in  8  instruction byte.
- `alu_instruction`  out  8  {5'b0, ir[2:0]}; 8'h00 outside calculate.
- `alu_in1`, `alu_in2`  out  8  r1, r2, driven continuously.
- `alu_result`  in  8  combinational ALU result.
- `in_data`  in  8, `in_valid`  in  1, `in_ready`  out  1  external input stream.
- `out_data`  out  8, `out_valid`  out  1, `out_ready`  in  1  external output stream.
- `pc`  out  8  current program counter, for debug.

## Operation
- States: IDLE, FETCH, EXEC, IN_WAIT, OUT_WAIT.
- IDLE: if `run`=1, go to FETCH.
- FETCH: assert `prog_req`. On `prog_ack`, latch `prog_data` into ir and go to EXEC.
- EXEC decodes ir[7:6]:
  - 00 immediate: r0 ← {2'b00, ir[5:0]}.
  - 01 calculate: r3 ← `alu_result`.
  - 10 copy: src = ir[5:3], dst = ir[2:0].
    - Register index 0–5 is r0–r5. Index 7 reads 8'h00; a write to 7 is discarded.
    - src = 6: go to IN_WAIT.
    - src ≠ 6 and dst = 6: load out_data ← src and go to OUT_WAIT.
    - Otherwise dst ← src in EXEC.
  - 11 condition: evaluate signed r3 against ir[2:0]:
    - 0 never, 1 =0, 2 <0, 3 ≤0, 4 always, 5 ≠0, 6 ≥0, 7 >0.
    - True: pc ← r0. False: pc ← pc+1.
- Every non-jump instruction sets pc ← pc+1 on completion. pc wraps 8'hFF → 8'h00.
- IN_WAIT:
  - Assert `in_ready`. On `in_valid`, capture `in_data`.
  - dst = 6: out_data ← captured byte, go to OUT_WAIT.
  - Otherwise write dst and complete.
- OUT_WAIT: assert `out_valid`. On `out_ready`, the instruction completes.
- Completion: go to FETCH if `run`=1, else IDLE.
- `run` is sampled only at completion and in IDLE.

## Timing
- Reset values: state IDLE, pc = RESET_PC, ir and r0–r5 = 0, `prog_req` = `in_ready` = `out_valid` = 0, `out_data` = 0, `alu_instruction` = 0.
- Minimum 2 cycles per instruction: FETCH (with `prog_ack` asserted in the same cycle as `prog_req`) followed by EXEC.
- Each extra cycle of `prog_ack`, `in_valid` or `out_ready` low adds one cycle of latency.
- `prog_addr` is stable while `prog_req` is high.
- Transfers:
  - Input transfer is the cycle with `in_valid` & `in_ready`.
  - Output transfer is the cycle with `out_valid` & `out_ready`.
  - `out_data` is registered and stable while `out_valid` is high.
  - The next instruction's FETCH starts in the cycle after the transfer.
- Calculate: `alu_instruction` is valid during EXEC only. r3 is written at the EXEC clock edge, so the next instruction sees the new r3.
- Condition in EXEC uses the r0/r3 values as they stand at the start of EXEC.
- Reset mid-operation: asynchronous `rst` low immediately forces all reset values, including in IN_WAIT and OUT_WAIT. Handshakes are abandoned with no partial register write.
- `run` falling during FETCH or a wait state does not abort the current instruction.

## Test plan
- Program {0x05, 0x81 (r0→r1), 0x03, 0x82, 0x44 (ADD)} with zero-wait ack: r3 = 0x08. `alu_instruction` = 0x04 in the calculate EXEC cycle. pc = 5 after 10 cycles.
- r1 = 3, r2 = 5, instruction 0x45 (SUB): r3 = 0xFE. Then condition 0xC2 (<0) with r0 = 0x20: pc = 0x20. Condition 0xC7 (>0): pc = old pc+1.
- Copy 0xB6 (in→out) with `in_valid` delayed 3 cycles and `out_ready` delayed 2 cycles: `in_ready` high 4 cycles, then `out_valid` high 3 cycles. `out_data` equals the input byte. No register changes.
- RESET_PC = 0xFF, immediate at 0xFF: next `prog_addr` = 0x00.
- Assert `rst` low during OUT_WAIT: `out_valid` drops asynchronously and state is IDLE. After release with `run`=1, the first `prog_addr` = RESET_PC.
- Drop `run` during a stalled FETCH: the instruction completes, the FSM enters IDLE, and `prog_req` stays 0 until `run` returns.
